// File: rtl/blake2_seq_ctrl.sv
// blake2_seq_ctrl
//   Sequencer that drives the BLAKE2 hash core for on-board self-test.
//   It sends the three configuration bytes and then streams a message
//   from a byte source, zero-padded to whole 64-byte blocks. It then
//   waits for the core and collects the digest bytes.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start_i         start pulse, honoured only while idle
//   msg_len_i       message length in bytes, latched on an accepted start
//   src_*           byte source handshake (valid/ready)
//   core_data_o     byte to core (ui_in)
//   core_ctrl_o     {last,cfg,valid} to core (uio_in[2:0])
//   core_ready_i    core accepts the presented byte this cycle
//   core_hv_i       core digest byte valid
//   core_hash_i     core digest byte
//   dig_data_o      captured digest byte
//   dig_valid_o     one-cycle strobe per captured digest byte
//   busy_o          high whenever the sequencer is not idle
//   done_o          one-cycle pulse at the end of a sequence
//   err_o           sticky timeout flag, cleared by the next accepted start
//
// Optional feature (macro DIGEST_CHECK_EN)
//   Adds exp_data_i (expected digest byte, indexed by the capture count)
//   and match_o. match_o is high when every captured byte equals its
//   expected value. It is meaningful while done_o is high and is forced
//   low on a timeout.
module blake2_seq_ctrl #(
  parameter int MLEN_W   = 16,
  parameter int DIGEST_B = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MLEN_W-1:0] msg_len_i,
  input  logic [7:0]        src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic [7:0]        core_data_o,
  output logic [2:0]        core_ctrl_o,
  input  logic              core_ready_i,
  input  logic              core_hv_i,
  input  logic [7:0]        core_hash_i,
  output logic [7:0]        dig_data_o,
  output logic              dig_valid_o,
  output logic              busy_o,
  output logic              done_o,
`ifdef DIGEST_CHECK_EN
  input  logic [7:0]        exp_data_i,
  output logic              match_o,
`endif
  output logic              err_o
);

  // Byte count needs one extra bit: a maximum-length message pads to 2^MLEN_W.
  localparam int CNT_W  = MLEN_W + 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DCNT_W = $clog2(DIGEST_B + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_STREAM, S_PAD, S_WAIT, S_READ, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [MLEN_W-1:0] len_q, len_d;
  logic [1:0]        conf_idx_q, conf_idx_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DCNT_W-1:0] dig_cnt_q, dig_cnt_d;
  logic [7:0]        dig_data_q, dig_data_d;
  logic              dig_valid_q, dig_valid_d;
  logic              err_q, err_d;
`ifdef DIGEST_CHECK_EN
  logic              match_q, match_d;
`endif

  logic [CNT_W-1:0]  byte_cnt_inc;
  logic [DCNT_W-1:0] dig_cnt_inc;
  logic              stream_end;
  logic [15:0]       len16;
  logic              capture;

  assign byte_cnt_inc = byte_cnt_q + CNT_W'(1);
  assign dig_cnt_inc  = dig_cnt_q + DCNT_W'(1);
  assign stream_end   = (byte_cnt_inc == {1'b0, len_q});
  assign len16        = 16'(len_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      conf_idx_q  <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      dig_cnt_q   <= '0;
      dig_data_q  <= '0;
      dig_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef DIGEST_CHECK_EN
      match_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      conf_idx_q  <= conf_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      dig_cnt_q   <= dig_cnt_d;
      dig_data_q  <= dig_data_d;
      dig_valid_q <= dig_valid_d;
      err_q       <= err_d;
`ifdef DIGEST_CHECK_EN
      match_q     <= match_d;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    conf_idx_d  = conf_idx_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    dig_cnt_d   = dig_cnt_q;
    dig_data_d  = dig_data_q;
    dig_valid_d = 1'b0;
    err_d       = err_q;
    capture     = 1'b0;
`ifdef DIGEST_CHECK_EN
    match_d     = match_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = msg_len_i;
          err_d      = 1'b0;
          conf_idx_d = '0;
          byte_cnt_d = '0;
          wait_cnt_d = '0;
          dig_cnt_d  = '0;
`ifdef DIGEST_CHECK_EN
          match_d    = 1'b1;
`endif
          state_d    = S_CONF;
        end
      end
      S_CONF: begin
        if (core_ready_i) begin
          if (conf_idx_q == 2'd2) begin
            state_d = (len_q == '0) ? S_PAD : S_STREAM;
          end else begin
            conf_idx_d = conf_idx_q + 2'd1;
          end
        end
      end
      S_STREAM: begin
        if (src_valid_i && core_ready_i) begin
          byte_cnt_d = byte_cnt_inc;
          // A message ending exactly on a block boundary needs no padding.
          if (stream_end) begin
            state_d = (byte_cnt_inc[5:0] == 6'd0) ? S_WAIT : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (core_ready_i) begin
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_q[5:0] == 6'd63) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT, S_READ: begin
        if (core_hv_i) begin
          capture   = 1'b1;
          dig_cnt_d = dig_cnt_inc;
          state_d   = (dig_cnt_inc == DCNT_W'(DIGEST_B)) ? S_DONE : S_READ;
        end else if (state_q == S_WAIT) begin
          if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
`ifdef DIGEST_CHECK_EN
            match_d = 1'b0;
`endif
            state_d = S_DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      dig_valid_d = 1'b1;
      dig_data_d  = core_hash_i;
`ifdef DIGEST_CHECK_EN
      if (core_hash_i != exp_data_i) begin
        match_d = 1'b0;
      end
`endif
    end
  end

  // Core bus and status outputs
  always_comb begin
    src_ready_o = 1'b0;
    core_data_o = 8'h00;
    core_ctrl_o = 3'b000;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    case (state_q)
      S_CONF: begin
        core_ctrl_o = 3'b011;
        case (conf_idx_q)
          2'd0:    core_data_o = 8'(DIGEST_B);
          2'd1:    core_data_o = len16[7:0];
          default: core_data_o = len16[15:8];
        endcase
      end
      S_STREAM: begin
        core_data_o = src_data_i;
        src_ready_o = core_ready_i;
        core_ctrl_o = {src_valid_i && stream_end && (byte_cnt_inc[5:0] == 6'd0),
                       1'b0, src_valid_i};
      end
      S_PAD: begin
        core_ctrl_o = {(byte_cnt_q[5:0] == 6'd63), 1'b0, 1'b1};
      end
      default: begin
        core_ctrl_o = 3'b000;
      end
    endcase
  end

  assign dig_data_o  = dig_data_q;
  assign dig_valid_o = dig_valid_q;
  assign err_o       = err_q;
`ifdef DIGEST_CHECK_EN
  assign match_o     = match_q;
`endif

endmodule

// File: tb/tb_blake2_seq_ctrl.sv
// Self-checking bench for blake2_seq_ctrl.
// A transaction-level model predicts the byte stream to the core as a
// queue of beats, plus the digest strobes, done, busy and err. One
// compare process checks the DUT against it on every falling edge.
// Literal expectations pin the directed scenarios.
module tb_blake2_seq_ctrl;
  localparam int MLEN_W   = 16;
  localparam int DIGEST_B = 32;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] msg_len_i;
  logic [7:0]  src_data_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [7:0]  core_data_o;
  logic [2:0]  core_ctrl_o;
  logic        core_ready_i;
  logic        core_hv_i;
  logic [7:0]  core_hash_i;
  logic [7:0]  dig_data_o;
  logic        dig_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
`ifdef DIGEST_CHECK_EN
  logic [7:0]  exp_data_i;
  logic        match_o;
`endif

  always #5 clk = ~clk;

  blake2_seq_ctrl #(.MLEN_W(MLEN_W), .DIGEST_B(DIGEST_B), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .msg_len_i(msg_len_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .core_data_o(core_data_o), .core_ctrl_o(core_ctrl_o), .core_ready_i(core_ready_i),
    .core_hv_i(core_hv_i), .core_hash_i(core_hash_i),
    .dig_data_o(dig_data_o), .dig_valid_o(dig_valid_o),
    .busy_o(busy_o), .done_o(done_o),
`ifdef DIGEST_CHECK_EN
    .exp_data_i(exp_data_i), .match_o(match_o),
`endif
    .err_o(err_o)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       cfg;
    logic       last;
    logic       is_msg;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] msg_arr [0:1023];
  logic [7:0] hash_tab [0:DIGEST_B+3];
  logic [7:0] exp_tab [0:DIGEST_B+3];

  int checks = 0;
  int failures = 0;

  // model state: phase 0 idle, 1 sending, 2 hashing, 3 done cycle
  int         m_phase = 0;
  bit         m_err = 0;
  bit         m_match = 0;
  int         m_wait = 0;
  int         m_dig = 0;
  bit         m_dv_pend = 0;
  logic [7:0] m_dv_data = 8'h00;
  int         src_idx = 0;

  // observations of the DUT for the current transaction
  logic [7:0] obs_conf [0:2];
  int         obs_nconf = 0;
  int         obs_body = 0;
  int         obs_last_at = 0;
  int         obs_strobes = 0;
  int         obs_wait = 0;
  bit         obs_in_wait = 0;
  bit         seen_done = 0;

  // stimulus knobs
  int ready_mode = 0;
  bit valid_rand = 0;
  bit hv_en = 1;
  int hv_delay = 0;
  bit start_noise = 0;
  bit req_start = 0;
  int hv_sent;
  int hv_wait;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected beat sequence for a message of len bytes
  function automatic void buildExpected(input int len);
    int pad;
    int total;
    int k;
    logic [15:0] l16;
    l16 = 16'(len);
    exp_q.delete();
    exp_q.push_back('{data: 8'(DIGEST_B), cfg: 1'b1, last: 1'b0, is_msg: 1'b0});
    exp_q.push_back('{data: l16[7:0],     cfg: 1'b1, last: 1'b0, is_msg: 1'b0});
    exp_q.push_back('{data: l16[15:8],    cfg: 1'b1, last: 1'b0, is_msg: 1'b0});
    pad = (len == 0) ? 64 : (64 - (len % 64)) % 64;
    total = len + pad;
    for (k = 0; k < total; k++) begin
      if (k < len)
        exp_q.push_back('{data: msg_arr[k], cfg: 1'b0, last: (k == total - 1), is_msg: 1'b1});
      else
        exp_q.push_back('{data: 8'h00, cfg: 1'b0, last: (k == total - 1), is_msg: 1'b0});
    end
  endfunction

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    beat_t      f;
    bit         exp_valid;
    logic [2:0] exp_ctrl;
    bit         cap;
    logic [7:0] cap_data;
    cap = 1'b0;
    cap_data = 8'h00;

    checkOutput("dig_valid", 32'(dig_valid_o), 32'(m_dv_pend));
    if (m_dv_pend && dig_valid_o) checkOutput("dig_data", 32'(dig_data_o), 32'(m_dv_data));
    checkOutput("busy", 32'(busy_o), 32'(m_phase != 0));
    checkOutput("done", 32'(done_o), 32'(m_phase == 3));
    checkOutput("err", 32'(err_o), 32'(m_err));
`ifdef DIGEST_CHECK_EN
    if (m_phase == 3) checkOutput("match", 32'(match_o), 32'(m_match));
`endif
    if (dig_valid_o) obs_strobes++;
    if (done_o) seen_done = 1'b1;
    if (obs_in_wait && busy_o && !done_o) obs_wait++;
    if (done_o) obs_in_wait = 1'b0;

    if (m_phase == 1 && exp_q.size() != 0) begin
      f = exp_q[0];
      exp_valid = f.is_msg ? src_valid_i : 1'b1;
      exp_ctrl = exp_valid ? {f.last, f.cfg, 1'b1} : 3'b000;
      checkOutput("ctrl", 32'(core_ctrl_o), 32'(exp_ctrl));
      checkOutput("src_ready", 32'(src_ready_o), 32'(f.is_msg ? core_ready_i : 1'b0));
      if (exp_valid) checkOutput("data", 32'(core_data_o), 32'(f.data));
      if (exp_valid && core_ready_i) begin
        void'(exp_q.pop_front());
        if (f.cfg) begin
          if (obs_nconf < 3) obs_conf[obs_nconf] = core_data_o;
          obs_nconf++;
        end else begin
          obs_body++;
        end
        if (core_ctrl_o[2]) begin
          obs_last_at = obs_body;
          obs_in_wait = 1'b1;
        end
        if (f.is_msg) src_idx++;
        if (f.last) begin
          m_phase = 2;
          m_wait = 0;
          m_dig = 0;
        end
      end
    end else begin
      checkOutput("ctrl_quiet", 32'(core_ctrl_o), 32'd0);
      checkOutput("src_ready_quiet", 32'(src_ready_o), 32'd0);
      if (m_phase == 0) begin
        if (start_i) begin
          buildExpected(int'(msg_len_i));
          m_phase = 1;
          m_err = 1'b0;
          m_match = 1'b1;
          src_idx = 0;
          obs_nconf = 0; obs_body = 0; obs_last_at = 0;
          obs_strobes = 0; obs_wait = 0; obs_in_wait = 1'b0; seen_done = 1'b0;
        end
      end else if (m_phase == 2) begin
        if (core_hv_i) begin
          cap = 1'b1;
          cap_data = core_hash_i;
`ifdef DIGEST_CHECK_EN
          if (core_hash_i != exp_tab[m_dig]) m_match = 1'b0;
`endif
          m_dig++;
          if (m_dig == DIGEST_B) m_phase = 3;
        end else if (m_dig == 0) begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_err = 1'b1;
            m_match = 1'b0;
            m_phase = 3;
          end
        end
      end else if (m_phase == 3) begin
        m_phase = 0;
      end
    end
    m_dv_pend = cap;
    m_dv_data = cap_data;

    if (rst) begin
      m_phase = 0;
      m_err = 1'b0;
      m_dv_pend = 1'b0;
      src_idx = 0;
      exp_q.delete();
    end
  end

  // Input driver: source, core and start pulses, updated just after each rising edge
  initial begin
    start_i = 1'b0; src_data_i = 8'h00; src_valid_i = 1'b0;
    core_ready_i = 1'b0; core_hv_i = 1'b0; core_hash_i = 8'h00;
    hv_sent = 0; hv_wait = 0;
`ifdef DIGEST_CHECK_EN
    exp_data_i = 8'h00;
`endif
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       core_ready_i = 1'b1;
        1:       core_ready_i = ~core_ready_i;
        default: core_ready_i = 1'($urandom_range(0, 1));
      endcase
      src_valid_i = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_data_i = src_valid_i ? msg_arr[src_idx % 1024] : 8'($urandom);
      if (m_phase == 1) begin
        hv_sent = 0;
        hv_wait = hv_delay;
      end
      if ((m_phase == 2 || m_phase == 3) && hv_en) begin
        if (hv_wait > 0) begin
          hv_wait--;
          core_hv_i = 1'b0;
        end else begin
          core_hv_i = ($urandom_range(0, 2) != 0);
        end
      end else begin
        core_hv_i = 1'b0;
      end
      core_hash_i = core_hv_i ? hash_tab[hv_sent] : 8'($urandom);
      if (core_hv_i && hv_sent < DIGEST_B + 3) hv_sent++;
`ifdef DIGEST_CHECK_EN
      exp_data_i = exp_tab[(m_dig < DIGEST_B) ? m_dig : DIGEST_B];
`endif
      if (m_phase == 0) begin
        start_i = req_start;
        req_start = 1'b0;
      end else if (m_phase == 3) begin
        start_i = 1'b0;
      end else begin
        start_i = start_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fillRandomMsg();
    for (int i = 0; i < 1024; i++) msg_arr[i] = 8'($urandom);
  endtask

  task automatic applyStimulus(input int len, input int rmode, input bit vrand, input bit hven,
                               input int hdelay, input bit noise, input int corrupt);
    int guard;
    ready_mode = rmode; valid_rand = vrand; hv_en = hven; hv_delay = hdelay; start_noise = noise;
    for (int i = 0; i < DIGEST_B + 4; i++) begin
      hash_tab[i] = 8'($urandom);
      exp_tab[i] = hash_tab[i];
    end
    if (corrupt >= 0) exp_tab[corrupt] = ~hash_tab[corrupt];
    msg_len_i = 16'(len);
    req_start = 1'b1;
    guard = 0;
    while (req_start && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    guard = 0;
    while (!seen_done && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    if (!seen_done) begin
      checkOutput("done_seen", 32'(seen_done), 32'd1);
      doReset();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    msg_len_i = 16'h0000;
    fillRandomMsg();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_ctrl", 32'(core_ctrl_o), 32'd0);
    checkOutput("rst_data", 32'(core_data_o), 32'd0);
    checkOutput("rst_src_ready", 32'(src_ready_o), 32'd0);
    checkOutput("rst_dig_valid", 32'(dig_valid_o), 32'd0);
    checkOutput("rst_dig_data", 32'(dig_data_o), 32'd0);

    $display("[TB] abc message, ready always high");
    msg_arr[0] = 8'h61; msg_arr[1] = 8'h62; msg_arr[2] = 8'h63;
    applyStimulus(3, 0, 0, 1, 2, 0, -1);
    checkOutput("abc_conf0", 32'(obs_conf[0]), 32'h20);
    checkOutput("abc_conf1", 32'(obs_conf[1]), 32'h03);
    checkOutput("abc_conf2", 32'(obs_conf[2]), 32'h00);
    checkOutput("abc_bytes", 32'(obs_body), 32'd64);
    checkOutput("abc_last_at", 32'(obs_last_at), 32'd64);
    checkOutput("abc_strobes", 32'(obs_strobes), 32'd32);

    $display("[TB] empty message");
    applyStimulus(0, 0, 0, 1, 0, 1, -1);
    checkOutput("empty_bytes", 32'(obs_body), 32'd64);
    checkOutput("empty_last_at", 32'(obs_last_at), 32'd64);
    checkOutput("empty_strobes", 32'(obs_strobes), 32'd32);

    $display("[TB] 64-byte message, ready toggling");
    fillRandomMsg();
    applyStimulus(64, 1, 0, 1, 3, 0, -1);
    checkOutput("full_bytes", 32'(obs_body), 32'd64);
    checkOutput("full_last_at", 32'(obs_last_at), 32'd64);

    $display("[TB] core never answers");
    applyStimulus(5, 0, 0, 0, 0, 0, -1);
    checkOutput("to_err", 32'(err_o), 32'd1);
    checkOutput("to_strobes", 32'(obs_strobes), 32'd0);
    checkOutput("to_wait", 32'(obs_wait), 32'd16);

    $display("[TB] run after timeout clears err");
    applyStimulus(10, 2, 1, 1, 1, 1, -1);
    checkOutput("clr_err", 32'(err_o), 32'd0);

    $display("[TB] reset in the middle of streaming");
    fillRandomMsg();
    ready_mode = 0; valid_rand = 0; hv_en = 1; hv_delay = 0; start_noise = 0;
    msg_len_i = 16'd100;
    req_start = 1'b1;
    guard = 0;
    while (obs_body < 20 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    doReset();
    #1;
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_ctrl", 32'(core_ctrl_o), 32'd0);
    checkOutput("mid_rst_data", 32'(core_data_o), 32'd0);
    checkOutput("mid_rst_src_ready", 32'(src_ready_o), 32'd0);
    checkOutput("mid_rst_done_seen", 32'(seen_done), 32'd0);
    repeat (2) @(posedge clk);
    applyStimulus(100, 0, 0, 1, 0, 0, -1);
    checkOutput("after_rst_bytes", 32'(obs_body), 32'd128);
    checkOutput("after_rst_strobes", 32'(obs_strobes), 32'd32);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      int len;
      fillRandomMsg();
      case (t % 3)
        0:       len = $urandom_range(0, 200);
        1:       len = 64 * $urandom_range(1, 3);
        default: len = $urandom_range(60, 70);
      endcase
      applyStimulus(len, 2, 1, 1, $urandom_range(0, 6), 1,
                    (t % 2 == 1) ? int'($urandom_range(0, DIGEST_B - 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
